// File: rtl/a2bus_cycle_sampler.sv
// Apple II bus cycle sampler.
// Synchronises raw PHI1, tracks bus phase, captures address/RW in PHI1 and
// data in PHI0 at tunable offsets (optionally 3-tap majority voted), measures
// each bus cycle length, flags stretched cycles and reports bus sleep.
//
// Ports:
//   clk_logic_i      logic clock
//   reset_i          asynchronous reset, active-high
//   a2_phi1_i        raw PHI1 from the bus (asynchronous)
//   a2_a_i           bus address
//   a2_d_i           bus data
//   a2_rw_n_i        bus R/W (0 = write)
//   addr_o, rw_n_o   latched address / R/W
//   data_o           latched data
//   addr_strobe_o    one-clock pulse when addr_o/rw_n_o update
//   data_strobe_o    one-clock pulse at the data sample point
//   vote_error_o     pulses with data_strobe_o when the three votes disagreed
//   cycle_len_o      clocks in the last complete bus cycle (saturates at 127)
//   extended_cycle_o one-clock pulse when the last cycle was stretched
//   sleep_o          bus clock stalled (phase counter saturated)
module a2bus_cycle_sampler #(
  parameter int unsigned ADDR_WIDTH            = 16,
  parameter int unsigned DATA_WIDTH            = 8,
  parameter int unsigned CLOCK_SPEED_HZ        = 54_000_000,
  parameter int unsigned APPLE_HZ              = 14_318_181,
  parameter int unsigned CYCLE_COUNT           = CLOCK_SPEED_HZ * 14 / APPLE_HZ,
  parameter int unsigned APPLE_14M_CYCLE_COUNT = CLOCK_SPEED_HZ / APPLE_HZ,
  parameter int unsigned ADDR_COUNT            = 18,
  parameter int unsigned DATA_COUNT            = 15,
  parameter int unsigned DATA_VOTES            = 1,
  parameter int unsigned CAPTURE_READS         = 0,
  parameter int unsigned SYNC_STAGES           = 2
) (
  input  logic                  clk_logic_i,
  input  logic                  reset_i,
  input  logic                  a2_phi1_i,
  input  logic [ADDR_WIDTH-1:0] a2_a_i,
  input  logic [DATA_WIDTH-1:0] a2_d_i,
  input  logic                  a2_rw_n_i,
  output logic [ADDR_WIDTH-1:0] addr_o,
  output logic                  rw_n_o,
  output logic [DATA_WIDTH-1:0] data_o,
  output logic                  addr_strobe_o,
  output logic                  data_strobe_o,
  output logic                  vote_error_o,
  output logic [6:0]            cycle_len_o,
  output logic                  extended_cycle_o,
  output logic                  sleep_o
);

  localparam logic [5:0] CNT_MAX  = 6'd63;
  localparam logic [5:0] ADDR_CNT = 6'(ADDR_COUNT);
  localparam logic [5:0] DATA_CNT = 6'(DATA_COUNT);
  localparam logic [5:0] TAP0_CNT = 6'(DATA_COUNT - 2);
  localparam logic [5:0] TAP1_CNT = 6'(DATA_COUNT - 1);
  localparam logic [6:0] TMR_MAX  = 7'd127;
  localparam logic [6:0] EXT_LEN  = 7'(CYCLE_COUNT + APPLE_14M_CYCLE_COUNT);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    PHI1 = 2'd1,
    PHI0 = 2'd2
  } state_t;

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   phi1_s;
  logic                   phi1_q;
  logic                   rise;
  logic                   fall;
  logic [5:0]             cnt_q;
  state_t                 state_q;
  state_t                 state_d;
  logic                   cap_addr;
  logic                   cap_data;
  logic                   data_we;
  logic                   addr_valid_q;
  logic [DATA_WIDTH-1:0]  data_sel;
  logic                   disagree;
  logic [6:0]             timer_q;
  logic                   timer_valid_q;
  logic [6:0]             len_c;

  // PHI1 synchroniser and edge detect
  assign phi1_s = sync_q[SYNC_STAGES-1];
  assign rise   = phi1_s & ~phi1_q;
  assign fall   = ~phi1_s & phi1_q;

  always_ff @(posedge clk_logic_i or posedge reset_i) begin
    if (reset_i) begin
      sync_q <= '0;
      phi1_q <= 1'b0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], a2_phi1_i};
      phi1_q <= phi1_s;
    end
  end

  // Phase counter: restarts on each edge, saturates to signal sleep
  always_ff @(posedge clk_logic_i or posedge reset_i) begin
    if (reset_i) begin
      cnt_q <= CNT_MAX;
    end else if (rise || fall) begin
      cnt_q <= 6'd0;
    end else if (cnt_q != CNT_MAX) begin
      cnt_q <= cnt_q + 6'd1;
    end
  end

  assign sleep_o = (cnt_q == CNT_MAX);

  // Cycle-state register
  always_ff @(posedge clk_logic_i or posedge reset_i) begin
    if (reset_i) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next state and capture decodes; a rise beats counter saturation
  always_comb begin
    state_d  = state_q;
    cap_addr = 1'b0;
    cap_data = 1'b0;
    if (rise) begin
      state_d = PHI1;
    end else if (cnt_q == CNT_MAX) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        PHI1:    if (fall) state_d = PHI0;
        default: state_d = state_q;
      endcase
    end
    if (state_q == PHI1 && cnt_q == ADDR_CNT) begin
      cap_addr = 1'b1;
    end
    if (state_q == PHI0 && addr_valid_q && cnt_q == DATA_CNT) begin
      cap_data = 1'b1;
    end
  end

  // Data selection: single sample or bitwise majority of three taps
  generate
    if (DATA_VOTES == 3) begin : g_vote
      logic [DATA_WIDTH-1:0] tap0_q;
      logic [DATA_WIDTH-1:0] tap1_q;

      always_ff @(posedge clk_logic_i or posedge reset_i) begin
        if (reset_i) begin
          tap0_q <= '0;
          tap1_q <= '0;
        end else begin
          if (state_q == PHI0 && cnt_q == TAP0_CNT) tap0_q <= a2_d_i;
          if (state_q == PHI0 && cnt_q == TAP1_CNT) tap1_q <= a2_d_i;
        end
      end

      assign data_sel = (tap0_q & tap1_q) | (tap0_q & a2_d_i) | (tap1_q & a2_d_i);
      assign disagree = |((tap0_q ^ tap1_q) | (tap1_q ^ a2_d_i));
    end else begin : g_single
      assign data_sel = a2_d_i;
      assign disagree = 1'b0;
    end
  endgenerate

  // Reads only overwrite data_o when read capture is enabled
  assign data_we = cap_data && (!rw_n_o || (CAPTURE_READS != 0));

  // Address / data capture registers
  always_ff @(posedge clk_logic_i or posedge reset_i) begin
    if (reset_i) begin
      addr_o        <= '0;
      rw_n_o        <= 1'b1;
      addr_strobe_o <= 1'b0;
      addr_valid_q  <= 1'b0;
      data_o        <= '0;
      data_strobe_o <= 1'b0;
      vote_error_o  <= 1'b0;
    end else begin
      addr_strobe_o <= cap_addr;
      data_strobe_o <= cap_data;
      vote_error_o  <= cap_data & disagree;
      if (cap_addr) begin
        addr_o <= a2_a_i;
        rw_n_o <= a2_rw_n_i;
      end
      if (rise) begin
        addr_valid_q <= 1'b0;
      end else if (cap_addr) begin
        addr_valid_q <= 1'b1;
      end
      if (data_we) begin
        data_o <= data_sel;
      end
    end
  end

  // Length including the rise clock itself
  assign len_c = (timer_q == TMR_MAX) ? TMR_MAX : timer_q + 7'd1;

  // Cycle timer: measured rise to rise, invalid after reset or sleep
  always_ff @(posedge clk_logic_i or posedge reset_i) begin
    if (reset_i) begin
      timer_q          <= '0;
      timer_valid_q    <= 1'b0;
      cycle_len_o      <= '0;
      extended_cycle_o <= 1'b0;
    end else begin
      extended_cycle_o <= 1'b0;
      if (rise) begin
        timer_q       <= '0;
        timer_valid_q <= 1'b1;
        if (timer_valid_q) begin
          cycle_len_o      <= len_c;
          extended_cycle_o <= (len_c >= EXT_LEN);
        end
      end else begin
        timer_q <= len_c;
        if (cnt_q == CNT_MAX) begin
          timer_valid_q <= 1'b0;
        end
      end
    end
  end

endmodule

// File: tb/tb_a2bus_cycle_sampler.sv
// Bench for a2bus_cycle_sampler: u0 uses defaults, u1 uses 3-vote data with
// read capture. Both share the same bus stimulus.
module tb_a2bus_cycle_sampler;

  localparam int LAT      = 3;   // sync stages + edge-detect clock
  localparam int ADDR_OFF = LAT + 18 + 1;
  localparam int DATA_OFF = LAT + 15 + 1;

  typedef struct packed {
    logic [15:0] addr;
    logic        rw;
    logic [7:0]  data;
    logic        as;
    logic        ds;
    logic        verr;
    logic [6:0]  len;
    logic        ext;
    logic        sleep;
  } obs_t;

  typedef struct {
    int          high;
    int          low;
    logic [15:0] addr;
    logic        rw_n;
    logic [7:0]  data;
    logic [7:0]  glitch;
    logic [7:0]  exp_d0;
    logic [7:0]  exp_d1;
    logic        exp_ve1;
    logic [6:0]  exp_len;
    logic        exp_ext;
  } vec_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        phi1;
  logic [15:0] a;
  logic [7:0]  d;
  logic        rw_n;

  logic [15:0] addr0, addr1;
  logic        rw0, rw1;
  logic [7:0]  data0, data1;
  logic        as0, as1, ds0, ds1, ve0, ve1, ext0, ext1, sl0, sl1;
  logic [6:0]  len0, len1;

  obs_t o0, o1;
  int   checks = 0;
  int   failures = 0;
  vec_t vecs [9];

  always #5 clk = ~clk;

  a2bus_cycle_sampler u0 (
    .clk_logic_i(clk), .reset_i(rst), .a2_phi1_i(phi1), .a2_a_i(a), .a2_d_i(d),
    .a2_rw_n_i(rw_n), .addr_o(addr0), .rw_n_o(rw0), .data_o(data0),
    .addr_strobe_o(as0), .data_strobe_o(ds0), .vote_error_o(ve0),
    .cycle_len_o(len0), .extended_cycle_o(ext0), .sleep_o(sl0)
  );

  a2bus_cycle_sampler #(.DATA_VOTES(3), .CAPTURE_READS(1)) u1 (
    .clk_logic_i(clk), .reset_i(rst), .a2_phi1_i(phi1), .a2_a_i(a), .a2_d_i(d),
    .a2_rw_n_i(rw_n), .addr_o(addr1), .rw_n_o(rw1), .data_o(data1),
    .addr_strobe_o(as1), .data_strobe_o(ds1), .vote_error_o(ve1),
    .cycle_len_o(len1), .extended_cycle_o(ext1), .sleep_o(sl1)
  );

  always_comb begin
    o0 = '{addr: addr0, rw: rw0, data: data0, as: as0, ds: ds0, verr: ve0,
           len: len0, ext: ext0, sleep: sl0};
    o1 = '{addr: addr1, rw: rw1, data: data1, as: as1, ds: ds1, verr: ve1,
           len: len1, ext: ext1, sleep: sl1};
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s got=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic check_reset_vals(input string tag);
    obs_t o;
    for (int k = 0; k < 2; k++) begin
      o = (k == 0) ? o0 : o1;
      check($sformatf("%s.u%0d.addr", tag, k), 32'(o.addr), 32'h0);
      check($sformatf("%s.u%0d.rw_n", tag, k), 32'(o.rw), 32'h1);
      check($sformatf("%s.u%0d.data", tag, k), 32'(o.data), 32'h0);
      check($sformatf("%s.u%0d.len", tag, k), 32'(o.len), 32'h0);
      check($sformatf("%s.u%0d.sleep", tag, k), 32'(o.sleep), 32'h1);
      check($sformatf("%s.u%0d.pulses", tag, k), 32'({o.as, o.ds, o.verr, o.ext}), 32'h0);
    end
  endtask

  // One bus cycle; sample index i is the i-th negedge after PHI1 is raised
  task automatic run_cycle(input vec_t v, input int idx);
    int          na [2], oa [2], nd [2], od [2], ne [2];
    logic [15:0] av [2];
    logic        rv [2], vv [2];
    logic [7:0]  dv [2];
    obs_t        o;
    for (int k = 0; k < 2; k++) begin
      na[k] = 0; oa[k] = -1; nd[k] = 0; od[k] = -1; ne[k] = 0;
      av[k] = '0; rv[k] = 1'b0; vv[k] = 1'b0; dv[k] = '0;
    end
    for (int i = 0; i < v.high + v.low; i++) begin
      @(negedge clk);
      for (int k = 0; k < 2; k++) begin
        o = (k == 0) ? o0 : o1;
        if (o.as) begin na[k]++; oa[k] = i; av[k] = o.addr; rv[k] = o.rw; end
        if (o.ds) begin nd[k]++; od[k] = i; dv[k] = o.data; vv[k] = o.verr; end
        if (o.ext) ne[k]++;
      end
      phi1 = (i < v.high);
      a    = v.addr;
      rw_n = v.rw_n;
      d    = (i == v.high + 17) ? (v.data ^ v.glitch) : v.data;
    end
    for (int k = 0; k < 2; k++) begin
      o = (k == 0) ? o0 : o1;
      check($sformatf("v%0d.u%0d.addr_strobes", idx, k), 32'(na[k]), 32'd1);
      check($sformatf("v%0d.u%0d.addr_off", idx, k), 32'(oa[k]), 32'(ADDR_OFF));
      check($sformatf("v%0d.u%0d.addr", idx, k), 32'(av[k]), 32'(v.addr));
      check($sformatf("v%0d.u%0d.rw_n", idx, k), 32'(rv[k]), 32'(v.rw_n));
      check($sformatf("v%0d.u%0d.data_strobes", idx, k), 32'(nd[k]), 32'd1);
      check($sformatf("v%0d.u%0d.data_off", idx, k), 32'(od[k]), 32'(v.high + DATA_OFF));
      check($sformatf("v%0d.u%0d.data", idx, k), 32'(dv[k]),
            32'((k == 0) ? v.exp_d0 : v.exp_d1));
      check($sformatf("v%0d.u%0d.vote_err", idx, k), 32'(vv[k]),
            32'((k == 0) ? 1'b0 : v.exp_ve1));
      check($sformatf("v%0d.u%0d.cycle_len", idx, k), 32'(o.len), 32'(v.exp_len));
      check($sformatf("v%0d.u%0d.ext_pulses", idx, k), 32'(ne[k]), 32'(v.exp_ext));
      check($sformatf("v%0d.u%0d.sleep", idx, k), 32'(o.sleep), 32'h0);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    obs_t o;
    int   first_sl [2];
    int   nstr [2];

    //            high low  addr      rw    data   glitch d0     d1     ve1   len    ext
    vecs[0] = '{26, 26, 16'hC0E9, 1'b0, 8'h5A, 8'h00, 8'h5A, 8'h5A, 1'b0, 7'd0,  1'b0};
    vecs[1] = '{26, 26, 16'hC0E9, 1'b0, 8'h5A, 8'h00, 8'h5A, 8'h5A, 1'b0, 7'd52, 1'b0};
    vecs[2] = '{26, 26, 16'hC0E9, 1'b1, 8'h33, 8'h00, 8'h5A, 8'h33, 1'b0, 7'd52, 1'b0};
    vecs[3] = '{26, 26, 16'hC0E9, 1'b0, 8'hA4, 8'h01, 8'hA4, 8'hA4, 1'b1, 7'd52, 1'b0};
    vecs[4] = '{30, 26, 16'h1234, 1'b0, 8'h11, 8'h00, 8'h11, 8'h11, 1'b0, 7'd52, 1'b0};
    vecs[5] = '{26, 26, 16'h1234, 1'b0, 8'h22, 8'h00, 8'h22, 8'h22, 1'b0, 7'd56, 1'b1};
    vecs[6] = '{26, 26, 16'h1234, 1'b0, 8'h23, 8'h00, 8'h23, 8'h23, 1'b0, 7'd52, 1'b0};
    vecs[7] = '{26, 26, 16'hBEEF, 1'b0, 8'h77, 8'h00, 8'h77, 8'h77, 1'b0, 7'd52, 1'b0};
    vecs[8] = '{26, 26, 16'hBEEF, 1'b0, 8'h78, 8'h00, 8'h78, 8'h78, 1'b0, 7'd52, 1'b0};

    rst = 1'b1; phi1 = 1'b0; a = '0; d = '0; rw_n = 1'b1;
    repeat (3) @(negedge clk);
    check_reset_vals("reset");
    rst = 1'b0;
    repeat (5) @(negedge clk);
    check_reset_vals("post_reset_idle");

    for (int v = 0; v < 7; v++) run_cycle(vecs[v], v);

    // Bus stall after the last fall of vector 6 (fall detected at offset 29)
    for (int k = 0; k < 2; k++) begin first_sl[k] = -1; nstr[k] = 0; end
    for (int j = 52; j < 122; j++) begin
      @(negedge clk);
      for (int k = 0; k < 2; k++) begin
        o = (k == 0) ? o0 : o1;
        if (o.sleep && first_sl[k] < 0) first_sl[k] = j;
        if (o.as || o.ds || o.ext) nstr[k]++;
      end
      phi1 = 1'b0;
    end
    for (int k = 0; k < 2; k++) begin
      o = (k == 0) ? o0 : o1;
      check($sformatf("sleep.u%0d.first_off", k), 32'(first_sl[k]), 32'(26 + LAT + 63));
      check($sformatf("sleep.u%0d.sleep", k), 32'(o.sleep), 32'h1);
      check($sformatf("sleep.u%0d.pulses", k), 32'(nstr[k]), 32'h0);
      check($sformatf("sleep.u%0d.len_held", k), 32'(o.len), 32'd52);
      check($sformatf("sleep.u%0d.data_held", k), 32'(o.data), 32'h23);
    end

    for (int v = 7; v < 9; v++) run_cycle(vecs[v], v);

    // Reset asserted mid-PHI0, before the data sample point
    for (int i = 0; i < 34; i++) begin
      @(negedge clk);
      phi1 = (i < 26); a = 16'h5555; rw_n = 1'b0; d = 8'h99;
    end
    @(negedge clk);
    check("rstmid.u0.addr_pre", 32'(o0.addr), 32'h5555);
    check("rstmid.u1.len_pre", 32'(o1.len), 32'd52);
    rst = 1'b1;
    #1;
    check_reset_vals("rstmid");
    for (int k = 0; k < 2; k++) nstr[k] = 0;
    for (int j = 0; j < 30; j++) begin
      @(negedge clk);
      for (int k = 0; k < 2; k++) begin
        o = (k == 0) ? o0 : o1;
        if (o.as || o.ds || o.ext || o.verr) nstr[k]++;
      end
      if (j == 3) rst = 1'b0;
    end
    for (int k = 0; k < 2; k++) begin
      o = (k == 0) ? o0 : o1;
      check($sformatf("rstmid.u%0d.no_pulses", k), 32'(nstr[k]), 32'h0);
      check($sformatf("rstmid.u%0d.data", k), 32'(o.data), 32'h0);
      check($sformatf("rstmid.u%0d.sleep", k), 32'(o.sleep), 32'h1);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/a2bus_cycle_sampler.md
Name: a2bus_cycle_sampler

Overview:
- Parametrised next-generation Apple II bus sampler.
- Synchronises raw PHI1 internally and tracks bus phase with a cycle-state machine.
- Captures address/RW at a tunable PHI1 offset and data at a tunable PHI0 offset, with optional 3-tap majority voting on data.
- Measures every bus cycle length, flags stretched cycles, and reports bus sleep.
- Sits between the slot pins and the a2bus_if fan-out, in the clk_logic_i domain.

Parameters:
- ADDR_WIDTH, 16, captured address width.
- DATA_WIDTH, 8, captured data width.
- CLOCK_SPEED_HZ, 54_000_000, logic clock frequency.
- APPLE_HZ, 14_318_181, Apple 14M reference frequency.
- CYCLE_COUNT, CLOCK_SPEED_HZ*14/APPLE_HZ (52), nominal clocks per bus cycle.
- APPLE_14M_CYCLE_COUNT, CLOCK_SPEED_HZ/APPLE_HZ (3), clocks per 14M tick.
- ADDR_COUNT, 18, phase count in PHI1 at which address is sampled; legal range 0..62.
- DATA_COUNT, 15, phase count in PHI0 at which data is sampled; legal range 2..62.
- DATA_VOTES, 1, 1 = single sample, 3 = bitwise majority of three samples.
- CAPTURE_READS, 0, 1 = latch data_i on read cycles as well as write cycles.
- SYNC_STAGES, 2, PHI1 synchroniser depth; minimum 2.

Ports:
- clk_logic_i  in  1  logic clock.
- reset_i  in  1  asynchronous reset, active-high.
- a2_phi1_i  in  1  raw PHI1 from the bus, asynchronous.
- a2_a_i  in  ADDR_WIDTH  bus address.
- a2_d_i  in  DATA_WIDTH  bus data.
- a2_rw_n_i  in  1  bus R/W (0 = write).
- addr_o  out  ADDR_WIDTH  latched address.
- rw_n_o  out  1  latched R/W.
- data_o  out  DATA_WIDTH  latched data.
- addr_strobe_o  out  1  one-clock pulse when addr_o/rw_n_o update.
- data_strobe_o  out  1  one-clock pulse marking a data sample point.
- vote_error_o  out  1  pulses with data_strobe_o when the three votes disagreed.
- cycle_len_o  out  7  clocks in the last complete bus cycle, saturating at 127.
- extended_cycle_o  out  1  one-clock pulse when the last cycle was stretched.
- sleep_o  out  1  bus clock stalled.

Behaviour:
- Reset (async, on assertion): addr_o=0, data_o=0, rw_n_o=1, all strobes/pulses=0, cycle_len_o=0.
  - Phase counter = 63, so sleep_o=1; state = IDLE; cycle timer invalid.
- Synchronisation: phi1_s is the output of the SYNC_STAGES flop chain.
  - rise/fall are phi1_s compared with its previous value.
  - All timing below is relative to the clock on which rise/fall is detected.
- Phase counter (6 bits):
  - Cleared to 0 on rise or fall.
  - Otherwise increments, saturating at 63.
  - sleep_o = (counter == 63), combinational from the register.
- State machine:
  - IDLE -> PHI1 on rise.
  - PHI1 -> PHI0 on fall.
  - PHI0 -> PHI1 on rise.
  - Any state -> IDLE when the counter reaches 63.
  - Rise wins over saturation on the same clock.
- Address capture: in PHI1 with counter == ADDR_COUNT, register a2_a_i and a2_rw_n_i and pulse addr_strobe_o.
  - Outputs and strobe become visible together one clock later.
  - Sets addr_valid; addr_valid clears on rise.
  - No capture in IDLE, so the partial phase after reset or wake produces no strobe.
- Data capture: in PHI0 with addr_valid and counter == DATA_COUNT, pulse data_strobe_o (registered, one-clock latency).
  - DATA_VOTES=1: data_o <= a2_d_i.
  - DATA_VOTES=3: data_i is tapped at DATA_COUNT-2 and DATA_COUNT-1; data_o <= bitwise majority(tap0, tap1, a2_d_i).
  - vote_error_o pulses if any bit of the three samples differs; it is always 0 when DATA_VOTES=1.
  - data_o updates only if rw_n_o==0 or CAPTURE_READS=1; the strobe fires regardless.
  - vote_error_o is still computed on read cycles with CAPTURE_READS=0.
- Cycle timer (7 bits): increments every clock, saturating at 127; cleared on rise.
  - On rise with the timer valid: cycle_len_o <= timer; extended_cycle_o pulses if timer >= CYCLE_COUNT + APPLE_14M_CYCLE_COUNT.
  - The timer becomes valid on the first rise after reset or IDLE.
  - That first rise updates nothing and produces no extended pulse.
- Outputs hold their values through sleep; only the strobe/pulse outputs return to 0.

Test Plan:
- Nominal cycles (PHI1 26 clk high, 26 low), A=0xC0E9, write, D=0x5A:
  - addr_strobe_o fires 19 clk after detected rise, with addr_o=0xC0E9 and rw_n_o=0.
  - data_strobe_o fires 16 clk after fall, with data_o=0x5A.
  - From the 2nd rise onward: cycle_len_o=52, extended_cycle_o=0.
- Read cycle, D=0x33, CAPTURE_READS=0:
  - data_strobe_o pulses; data_o keeps the prior value 0x5A.
  - Repeat with CAPTURE_READS=1: data_o=0x33.
- DATA_VOTES=3, data bit 0 glitched to 1 at tap DATA_COUNT-1 only, bus value 0xA4:
  - data_o=0xA4, vote_error_o=1 together with data_strobe_o.
- Stretched cycle with PHI1 high for 30 clk (cycle 56):
  - cycle_len_o=56 and extended_cycle_o pulses (56 >= 55).
  - The following 52-clk cycle pulses nothing.
- Hold PHI1 static 70 clk:
  - sleep_o rises 63 clk after the last edge; state returns to IDLE.
  - The next rise gives no extended pulse and no cycle_len_o update; the address strobe resumes in that phase.
- Assert reset_i mid-PHI0 before DATA_COUNT:
  - Outputs return immediately to reset values (rw_n_o=1, sleep_o=1).
  - No data_strobe_o occurs for the interrupted cycle.
